// File: rtl/out_fifo_multi_if.sv
// Handshake and status bundle between the sample producer/consumer and out_fifo_multi.
// Widths follow the FIFO parameters so both sides agree on lane packing.
interface out_fifo_multi_if #(
  parameter int NUM_CH    = 10,
  parameter int D_WIDTH   = 8,
  parameter int DEPTH     = 8,
  parameter int SERIALIZE = 1
);
  localparam int Q_WIDTH = (SERIALIZE != 0) ? D_WIDTH / 2 : D_WIDTH;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic                      WREN;
  logic [NUM_CH*D_WIDTH-1:0] D;
  logic                      RDEN;
  logic [NUM_CH*Q_WIDTH-1:0] Q;
  logic                      EMPTY;
  logic                      ALMOSTEMPTY;
  logic                      FULL;
  logic                      ALMOSTFULL;
  logic [CNT_W-1:0]          COUNT;
  logic                      OVERFLOW;
  logic                      UNDERFLOW;

  modport slave (
    input  WREN, D, RDEN,
    output Q, EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL, COUNT, OVERFLOW, UNDERFLOW
  );

  modport master (
    output WREN, D, RDEN,
    input  Q, EMPTY, ALMOSTEMPTY, FULL, ALMOSTFULL, COUNT, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/out_fifo_multi.sv
// Single-clock multi-lane output FIFO with optional 2:1 read serialisation (low half first),
// occupancy count, almost flags and registered over/underflow pulses.
module out_fifo_multi #(
  parameter int NUM_CH             = 10,
  parameter int D_WIDTH            = 8,
  parameter int DEPTH              = 8,
  parameter int SERIALIZE          = 1,
  parameter int ALMOST_EMPTY_VALUE = 1,
  parameter int ALMOST_FULL_VALUE  = 1,
  parameter int OUTPUT_DISABLE     = 0
) (
  input logic              CLK,
  input logic              RESET,
  out_fifo_multi_if.slave  bus
);
  localparam int Q_WIDTH = (SERIALIZE != 0) ? D_WIDTH / 2 : D_WIDTH;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int EW      = NUM_CH * D_WIDTH;
  localparam int QW      = NUM_CH * Q_WIDTH;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_VALUE);
  localparam logic [CW-1:0] AF_C    = CW'(DEPTH - ALMOST_FULL_VALUE);

  localparam bit PARAM_OK =
    (NUM_CH >= 1) && (NUM_CH <= 16) && (D_WIDTH >= 1) &&
    ((SERIALIZE == 0) || (SERIALIZE == 1)) &&
    ((SERIALIZE == 0) || (D_WIDTH % 2 == 0)) &&
    (DEPTH >= 4) && (DEPTH <= 256) && ((DEPTH & (DEPTH - 1)) == 0) &&
    (ALMOST_EMPTY_VALUE >= 1) && (ALMOST_EMPTY_VALUE <= DEPTH / 2) &&
    (ALMOST_FULL_VALUE >= 1) && (ALMOST_FULL_VALUE <= DEPTH / 2) &&
    ((OUTPUT_DISABLE == 0) || (OUTPUT_DISABLE == 1));

  generate
    if (!PARAM_OK) begin : g_param_err
      $fatal(1, "out_fifo_multi: illegal parameter combination");
    end
  endgenerate

  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          phase_q, phase_d;
  logic [QW-1:0] q_q, q_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          full, empty, wr_acc, rd_acc, pop;
  logic [EW-1:0] head;
  int            hoff;

  always_comb begin
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);
    wr_acc   = bus.WREN & ~full;
    rd_acc   = bus.RDEN & ~empty;
    // A serialised entry only leaves the FIFO once its high half has been read.
    pop      = rd_acc & ((SERIALIZE == 0) | phase_q);
    head     = mem_q[rd_ptr_q];
    hoff     = ((SERIALIZE != 0) && phase_q) ? Q_WIDTH : 0;

    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    phase_d  = (rd_acc && (SERIALIZE != 0)) ? ~phase_q : phase_q;

    count_d  = count_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    q_d = (OUTPUT_DISABLE != 0) ? '0 : q_q;
    if (rd_acc) begin
      for (int n = 0; n < NUM_CH; n++) begin
        q_d[n*Q_WIDTH +: Q_WIDTH] = head[n*D_WIDTH + hoff +: Q_WIDTH];
      end
    end

    ovf_d = bus.WREN & full;
    unf_d = bus.RDEN & empty;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      phase_q  <= 1'b0;
      q_q      <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      phase_q  <= phase_d;
      q_q      <= q_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is data-only: contents are meaningless until written, so no reset here.
  always_ff @(posedge CLK) begin
    if (!RESET && wr_acc) begin
      mem_q[wr_ptr_q] <= bus.D;
    end
  end

  assign bus.Q           = q_q;
  assign bus.EMPTY       = empty;
  assign bus.ALMOSTEMPTY = (count_q <= AE_C);
  assign bus.FULL        = full;
  assign bus.ALMOSTFULL  = (count_q >= AF_C);
  assign bus.COUNT       = count_q;
  assign bus.OVERFLOW    = ovf_q;
  assign bus.UNDERFLOW   = unf_q;
endmodule

// File: tb/tb_out_fifo_multi.sv
// Directed bench for out_fifo_multi: serialised, output-disabled and non-serialised instances.
module tb_out_fifo_multi;
  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  out_fifo_multi_if #(.NUM_CH(2), .D_WIDTH(8), .DEPTH(8), .SERIALIZE(1)) bus0 ();
  out_fifo_multi_if #(.NUM_CH(2), .D_WIDTH(8), .DEPTH(8), .SERIALIZE(1)) bus1 ();
  out_fifo_multi_if #(.NUM_CH(2), .D_WIDTH(8), .DEPTH(8), .SERIALIZE(0)) bus2 ();

  out_fifo_multi #(.NUM_CH(2), .D_WIDTH(8), .DEPTH(8), .SERIALIZE(1),
                   .ALMOST_EMPTY_VALUE(1), .ALMOST_FULL_VALUE(1), .OUTPUT_DISABLE(0))
    dut0 (.CLK(clk), .RESET(rst0), .bus(bus0));
  out_fifo_multi #(.NUM_CH(2), .D_WIDTH(8), .DEPTH(8), .SERIALIZE(1),
                   .ALMOST_EMPTY_VALUE(1), .ALMOST_FULL_VALUE(1), .OUTPUT_DISABLE(1))
    dut1 (.CLK(clk), .RESET(rst1), .bus(bus1));
  out_fifo_multi #(.NUM_CH(2), .D_WIDTH(8), .DEPTH(8), .SERIALIZE(0),
                   .ALMOST_EMPTY_VALUE(1), .ALMOST_FULL_VALUE(1), .OUTPUT_DISABLE(0))
    dut2 (.CLK(clk), .RESET(rst2), .bus(bus2));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entry i for the fill test: channel1 = C0+(7-i), channel0 = 70+i.
  function automatic logic [15:0] ent(input int i);
    logic [7:0] c1, c0;
    c1 = 8'(8'hC0 + (7 - i));
    c0 = 8'(8'h70 + i);
    return {c1, c0};
  endfunction

  function automatic logic [7:0] lo(input logic [15:0] e);
    return {e[11:8], e[3:0]};
  endfunction

  function automatic logic [7:0] hi(input logic [15:0] e);
    return {e[15:12], e[7:4]};
  endfunction

  function automatic logic [15:0] val(input int k);
    return 16'(k * 16'h0301 + 16'h1122);
  endfunction

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    bus0.WREN = 1'b0; bus0.RDEN = 1'b0; bus0.D = '0;
    bus1.WREN = 1'b0; bus1.RDEN = 1'b0; bus1.D = '0;
    bus2.WREN = 1'b0; bus2.RDEN = 1'b0; bus2.D = '0;
    tick();
    tick();
    chk("rst_empty",  32'(bus0.EMPTY), 32'd1);
    chk("rst_aempty", 32'(bus0.ALMOSTEMPTY), 32'd1);
    chk("rst_full",   32'(bus0.FULL), 32'd0);
    chk("rst_afull",  32'(bus0.ALMOSTFULL), 32'd0);
    chk("rst_count",  32'(bus0.COUNT), 32'd0);
    chk("rst_q",      32'(bus0.Q), 32'd0);
    chk("rst_ovf",    32'(bus0.OVERFLOW), 32'd0);
    chk("rst_unf",    32'(bus0.UNDERFLOW), 32'd0);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // Single entry split into low then high halves.
    bus0.WREN = 1'b1; bus0.D = 16'hA53C;
    tick();
    bus0.WREN = 1'b0;
    chk("wr1_count", 32'(bus0.COUNT), 32'd1);
    chk("wr1_empty", 32'(bus0.EMPTY), 32'd0);
    bus0.RDEN = 1'b1;
    tick();
    chk("rd_lo_q",     32'(bus0.Q), 32'h5C);
    chk("rd_lo_count", 32'(bus0.COUNT), 32'd1);
    tick();
    chk("rd_hi_q",     32'(bus0.Q), 32'hA3);
    chk("rd_hi_count", 32'(bus0.COUNT), 32'd0);
    chk("rd_hi_empty", 32'(bus0.EMPTY), 32'd1);

    // Read while empty.
    tick();
    chk("unf_pulse", 32'(bus0.UNDERFLOW), 32'd1);
    chk("unf_q_hold", 32'(bus0.Q), 32'hA3);
    chk("unf_count", 32'(bus0.COUNT), 32'd0);
    bus0.RDEN = 1'b0;
    tick();
    chk("unf_clear", 32'(bus0.UNDERFLOW), 32'd0);
    chk("idle_q_hold", 32'(bus0.Q), 32'hA3);

    // Fill to full, then one overflowing write.
    for (int i = 0; i < 8; i++) begin
      bus0.WREN = 1'b1; bus0.D = ent(i);
      tick();
      chk("fill_count", 32'(bus0.COUNT), 32'(i + 1));
      chk("fill_afull", 32'(bus0.ALMOSTFULL), 32'((i + 1) >= 7));
    end
    chk("fill_full", 32'(bus0.FULL), 32'd1);
    chk("fill_aempty", 32'(bus0.ALMOSTEMPTY), 32'd0);
    bus0.D = ent(8);
    tick();
    chk("ovf_pulse", 32'(bus0.OVERFLOW), 32'd1);
    chk("ovf_count", 32'(bus0.COUNT), 32'd8);
    bus0.WREN = 1'b0;
    tick();
    chk("ovf_clear", 32'(bus0.OVERFLOW), 32'd0);

    // Full with a popping read in the same edge as a write.
    bus0.RDEN = 1'b1;
    tick();
    chk("full_rd_lo", 32'(bus0.Q), 32'(lo(ent(0))));
    chk("full_rd_cnt", 32'(bus0.COUNT), 32'd8);
    bus0.WREN = 1'b1; bus0.D = ent(8);
    tick();
    chk("full_pop_q", 32'(bus0.Q), 32'(hi(ent(0))));
    chk("full_pop_cnt", 32'(bus0.COUNT), 32'd7);
    chk("full_pop_ovf", 32'(bus0.OVERFLOW), 32'd1);
    bus0.WREN = 1'b0;
    tick();
    chk("c7_lo_q", 32'(bus0.Q), 32'(lo(ent(1))));
    chk("c7_lo_cnt", 32'(bus0.COUNT), 32'd7);
    bus0.WREN = 1'b1;
    tick();
    chk("c7_pop_q", 32'(bus0.Q), 32'(hi(ent(1))));
    chk("c7_pop_cnt", 32'(bus0.COUNT), 32'd7);
    chk("c7_pop_ovf", 32'(bus0.OVERFLOW), 32'd0);
    bus0.WREN = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("drain_lo", 32'(bus0.Q), 32'(lo(ent(i))));
      tick();
      chk("drain_hi", 32'(bus0.Q), 32'(hi(ent(i))));
      chk("drain_cnt", 32'(bus0.COUNT), 32'(8 - i));
    end
    bus0.RDEN = 1'b0;
    tick();
    chk("drain_empty", 32'(bus0.EMPTY), 32'd1);

    // Reset with a half-read entry outstanding.
    bus0.WREN = 1'b1; bus0.D = 16'hDEAD;
    tick();
    bus0.WREN = 1'b0; bus0.RDEN = 1'b1;
    tick();
    chk("half_q", 32'(bus0.Q), 32'hED);
    bus0.RDEN = 1'b0; rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    chk("mid_rst_cnt", 32'(bus0.COUNT), 32'd0);
    chk("mid_rst_empty", 32'(bus0.EMPTY), 32'd1);
    chk("mid_rst_q", 32'(bus0.Q), 32'd0);
    bus0.WREN = 1'b1; bus0.D = 16'h1234;
    tick();
    bus0.WREN = 1'b0; bus0.RDEN = 1'b1;
    tick();
    chk("post_rst_lo", 32'(bus0.Q), 32'h24);
    tick();
    chk("post_rst_hi", 32'(bus0.Q), 32'h13);
    chk("post_rst_cnt", 32'(bus0.COUNT), 32'd0);
    bus0.RDEN = 1'b0;

    // Output-disable instance.
    bus1.WREN = 1'b1; bus1.D = 16'h1234;
    tick();
    bus1.WREN = 1'b0; bus1.RDEN = 1'b1;
    tick();
    chk("od_lo", 32'(bus1.Q), 32'h24);
    bus1.RDEN = 1'b0;
    tick();
    chk("od_idle_zero", 32'(bus1.Q), 32'd0);
    bus1.RDEN = 1'b1;
    tick();
    chk("od_hi", 32'(bus1.Q), 32'h13);
    tick();
    chk("od_unf_zero", 32'(bus1.Q), 32'd0);
    chk("od_unf_pulse", 32'(bus1.UNDERFLOW), 32'd1);
    bus1.RDEN = 1'b0;

    // Non-serialised instance: interleaved traffic across the pointer wrap.
    for (int k = 0; k < 20; k++) begin
      bus2.WREN = 1'b1; bus2.D = val(k); bus2.RDEN = (k >= 3);
      tick();
      if (k >= 3) chk("ns_q", 32'(bus2.Q), 32'(val(k - 3)));
      chk("ns_cnt", 32'(bus2.COUNT), 32'((k < 3) ? k + 1 : 3));
    end
    bus2.WREN = 1'b0; bus2.RDEN = 1'b1;
    for (int j = 17; j < 20; j++) begin
      tick();
      chk("ns_drain_q", 32'(bus2.Q), 32'(val(j)));
      chk("ns_drain_cnt", 32'(bus2.COUNT), 32'(19 - j));
    end
    bus2.RDEN = 1'b0;
    tick();
    chk("ns_empty", 32'(bus2.EMPTY), 32'd1);
    chk("ns_q_hold", 32'(bus2.Q), 32'(val(19)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
